escalonador_rr: RTL and testbench

Hardware round-robin process scheduler for the multiprogrammed CPU. It tracks up to NUM_PROC process slots, each as empty, ready, blocked-on-IO or finished, and counts the quantum in retired instructions. On quantum expiry, an IO instruction or process end, it requests a context switch and presents the next process and its code base address. It replaces the free-running quantum counter and sits beside the PC logic, which jumps to the save routine on switch_req and loads next_pc_base once the routine signals completion.

---
 rtl/escalonador_rr_if.sv | 29 ++
 rtl/escalonador_rr.sv | 120 ++++++++++++
 tb/tb_escalonador_rr.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/escalonador_rr_if.sv
// escalonador_rr_if: CPU-side control and context-switch signals of the round-robin scheduler
interface escalonador_rr_if;
    logic        start;
    logic [3:0]  proc_count;
    logic        instr_valid;
    logic        io_req;
    logic        io_done;
    logic [3:0]  io_done_proc;
    logic        proc_end;
    logic        switch_ack;
    logic        switch_req;
    logic [1:0]  switch_cause;
    logic [3:0]  cur_proc;
    logic [3:0]  next_proc;
    logic [31:0] next_pc_base;
    logic [7:0]  quantum_left;
    logic        idle;
    logic        all_done;

    modport master (
        output start, proc_count, instr_valid, io_req, io_done, io_done_proc, proc_end, switch_ack,
        input  switch_req, switch_cause, cur_proc, next_proc, next_pc_base, quantum_left, idle, all_done
    );

    modport slave (
        input  start, proc_count, instr_valid, io_req, io_done, io_done_proc, proc_end, switch_ack,
        output switch_req, switch_cause, cur_proc, next_proc, next_pc_base, quantum_left, idle, all_done
    );
endinterface

// File: rtl/escalonador_rr.sv
// escalonador_rr: round-robin process scheduler with quantum counting and context-switch requests
module escalonador_rr #(
    parameter int          NUM_PROC  = 10,
    parameter int          QUANTUM   = 16,
    parameter int unsigned PROC_BASE = 300,
    parameter int unsigned PROC_SIZE = 300
) (
    input  logic            clk,
    input  logic            reset,
    escalonador_rr_if.slave bus
);
    localparam logic [1:0] EMPTY = 2'd0, READY = 2'd1, BLOCKED = 2'd2, FINISHED = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SWITCH, S_WAIT, S_DONE} state_t;

    state_t                 state, state_n;
    logic [NUM_PROC:1][1:0] slot, slot_n;
    logic [3:0]             cur, cur_n, nxt, nxt_n, sel;
    logic [1:0]             cause, cause_n;
    logic [7:0]             qleft, qleft_n;
    logic                   wake, found, any_blocked, ev_end, ev_io, ev_exp;
    int                     idx;

    // state, slot table and switch bookkeeping registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            slot  <= '0;
            cur   <= '0;
            nxt   <= '0;
            cause <= '0;
            qleft <= '0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
            cur   <= cur_n;
            nxt   <= nxt_n;
            cause <= cause_n;
            qleft <= qleft_n;
        end
    end

    // wake-up first, then the running process's event, then round-robin selection
    always_comb begin
        state_n     = state;
        slot_n      = slot;
        cur_n       = cur;
        nxt_n       = nxt;
        cause_n     = cause;
        qleft_n     = qleft;
        found       = 1'b0;
        sel         = '0;
        any_blocked = 1'b0;
        idx         = 0;
        wake        = bus.io_done && bus.io_done_proc != 4'd0 && int'(bus.io_done_proc) <= NUM_PROC
                      && slot[bus.io_done_proc] == BLOCKED;
        if (wake) slot_n[bus.io_done_proc] = READY;
        ev_end = state == S_RUN && bus.proc_end;
        ev_io  = state == S_RUN && bus.io_req && !bus.proc_end;
        ev_exp = state == S_RUN && bus.instr_valid && qleft == 8'd1 && !bus.io_req && !bus.proc_end;
        if (ev_end) slot_n[cur] = FINISHED;
        if (ev_io) slot_n[cur] = BLOCKED;
        for (int k = 1; k <= NUM_PROC; k++) begin
            idx = int'(cur) + k;
            if (idx > NUM_PROC) idx = idx - NUM_PROC;
            if (!found && slot_n[idx] == READY) begin
                found = 1'b1;
                sel   = 4'(idx);
            end
            if (slot_n[k] == BLOCKED) any_blocked = 1'b1;
        end
        case (state)
            S_IDLE: if (bus.start) begin
                for (int i = 1; i <= NUM_PROC; i++) slot_n[i] = (i <= int'(bus.proc_count)) ? READY : EMPTY;
                if (bus.proc_count == 4'd0) state_n = S_DONE;
                else begin
                    state_n = S_SWITCH;
                    nxt_n   = 4'd1;
                    cause_n = 2'b11;
                end
            end
            S_RUN: begin
                if (bus.instr_valid && qleft != 8'd0) qleft_n = qleft - 8'd1;
                if (ev_exp && sel == cur) qleft_n = 8'(QUANTUM);
                else if (ev_end || ev_io || ev_exp) begin
                    if (found) begin
                        state_n = S_SWITCH;
                        nxt_n   = sel;
                        cause_n = ev_end ? 2'b10 : ev_io ? 2'b01 : 2'b00;
                    end else begin
                        state_n = any_blocked ? S_WAIT : S_DONE;
                        cur_n   = '0;
                        nxt_n   = '0;
                        qleft_n = '0;
                    end
                end
            end
            S_SWITCH: if (bus.switch_ack) begin
                state_n = S_RUN;
                cur_n   = nxt;
                qleft_n = 8'(QUANTUM);
            end
            S_WAIT: if (wake) begin
                state_n = S_SWITCH;
                nxt_n   = bus.io_done_proc;
                cause_n = 2'b01;
            end
            default: ;
        endcase
    end

    assign bus.switch_req   = state == S_SWITCH;
    assign bus.switch_cause = cause;
    assign bus.cur_proc     = cur;
    assign bus.next_proc    = nxt;
    assign bus.next_pc_base = (nxt == 4'd0) ? 32'd0 : 32'(PROC_BASE) + (32'(nxt) - 32'd1) * 32'(PROC_SIZE);
    assign bus.quantum_left = qleft;
    assign bus.idle         = state == S_WAIT;
    assign bus.all_done     = state == S_DONE;
endmodule

// File: tb/tb_escalonador_rr.sv
// tb_escalonador_rr: directed and randomized checks of escalonador_rr against a behavioural scheduler model
module tb_escalonador_rr;
    localparam int NP = 10, QUANTUM = 16, PROC_BASE = 300, PROC_SIZE = 300;
    localparam int EMP = 0, RDY = 1, BLK = 2, FIN = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_SW = 2, M_WAIT = 3, M_DONE = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ms, m_cur, m_nxt, m_cause, m_q;
    int   st[1:NP];

    escalonador_rr_if bus();

    escalonador_rr #(.NUM_PROC(NP), .QUANTUM(QUANTUM), .PROC_BASE(PROC_BASE), .PROC_SIZE(PROC_SIZE)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic clear_in();
        bus.start = 0;
        bus.proc_count = 0;
        bus.instr_valid = 0;
        bus.io_req = 0;
        bus.io_done = 0;
        bus.io_done_proc = 0;
        bus.proc_end = 0;
        bus.switch_ack = 0;
    endtask

    task automatic model_reset();
        ms = M_IDLE;
        m_cur = 0;
        m_nxt = 0;
        m_cause = 0;
        m_q = 0;
        for (int p = 1; p <= NP; p++) st[p] = EMP;
    endtask

    function automatic int pick();
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (m_cur - 1 + k) % NP + 1;
            if (st[p] == RDY) return p;
        end
        return 0;
    endfunction

    function automatic bit blocked_left();
        for (int p = 1; p <= NP; p++) if (st[p] == BLK) return 1;
        return 0;
    endfunction

    task automatic model_step();
        bit woke = 0;
        int id, p, c;
        id = int'(bus.io_done_proc);
        if (bus.io_done && id >= 1 && id <= NP) begin
            if (st[id] == BLK) begin
                st[id] = RDY;
                woke = 1;
            end
        end
        case (ms)
            M_IDLE: if (bus.start) begin
                for (int q = 1; q <= NP; q++) st[q] = (q <= int'(bus.proc_count)) ? RDY : EMP;
                if (bus.proc_count == 0) ms = M_DONE;
                else begin
                    ms = M_SW;
                    m_nxt = 1;
                    m_cause = 3;
                end
            end
            M_RUN: if (bus.proc_end || bus.io_req || (bus.instr_valid && m_q == 1)) begin
                c = bus.proc_end ? 2 : bus.io_req ? 1 : 0;
                if (c == 2) st[m_cur] = FIN;
                else if (c == 1) st[m_cur] = BLK;
                p = pick();
                if (c == 0 && p == m_cur) m_q = QUANTUM;
                else if (p != 0) begin
                    ms = M_SW;
                    m_nxt = p;
                    m_cause = c;
                end else begin
                    ms = blocked_left() ? M_WAIT : M_DONE;
                    m_cur = 0;
                end
            end else if (bus.instr_valid) m_q--;
            M_SW: if (bus.switch_ack) begin
                ms = M_RUN;
                m_cur = m_nxt;
                m_q = QUANTUM;
            end
            M_WAIT: if (woke) begin
                ms = M_SW;
                m_nxt = id;
                m_cause = 1;
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        check("switch_req", int'(bus.switch_req), int'(ms == M_SW));
        check("idle", int'(bus.idle), int'(ms == M_WAIT));
        check("all_done", int'(bus.all_done), int'(ms == M_DONE));
        check("cur_proc", int'(bus.cur_proc), m_cur);
        if (ms == M_RUN) check("quantum_left", int'(bus.quantum_left), m_q);
        if (ms == M_SW) begin
            check("next_proc", int'(bus.next_proc), m_nxt);
            check("next_pc_base", int'(bus.next_pc_base), PROC_BASE + (m_nxt - 1) * PROC_SIZE);
            check("switch_cause", int'(bus.switch_cause), m_cause);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
        clear_in();
    endtask

    task automatic do_reset();
        reset = 0;
        clear_in();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    task automatic start_run(input int pc);
        bus.proc_count = 4'(pc);
        bus.start = 1;
        step();
    endtask

    task automatic ack();
        bus.switch_ack = 1;
        step();
    endtask

    task automatic instrs(input int n);
        repeat (n) begin
            bus.instr_valid = 1;
            step();
        end
    endtask

    initial begin
        clear_in();
        model_reset();
        #3;
        check("rst_switch_req", int'(bus.switch_req), 0);
        do_reset();
        check("rst_cause", int'(bus.switch_cause), 0);
        check("rst_cur", int'(bus.cur_proc), 0);
        check("rst_next", int'(bus.next_proc), 0);
        check("rst_base", int'(bus.next_pc_base), 0);
        check("rst_quantum", int'(bus.quantum_left), 0);
        check("rst_idle", int'(bus.idle), 0);
        check("rst_all_done", int'(bus.all_done), 0);

        start_run(3);
        check("start_next", int'(bus.next_proc), 1);
        check("start_cause", int'(bus.switch_cause), 3);
        check("start_base", int'(bus.next_pc_base), 300);
        ack();
        check("start_cur", int'(bus.cur_proc), 1);
        check("start_quantum", int'(bus.quantum_left), 16);
        instrs(16);
        check("exp_req", int'(bus.switch_req), 1);
        check("exp_next", int'(bus.next_proc), 2);
        check("exp_base", int'(bus.next_pc_base), 600);
        check("exp_cause", int'(bus.switch_cause), 0);
        ack();
        check("exp_cur", int'(bus.cur_proc), 2);

        do_reset();
        start_run(2);
        ack();
        instrs(16);
        ack();
        bus.io_req = 1;
        step();
        check("io_next", int'(bus.next_proc), 1);
        check("io_cause", int'(bus.switch_cause), 1);
        ack();
        bus.io_req = 1;
        step();
        check("wait_idle", int'(bus.idle), 1);
        check("wait_cur", int'(bus.cur_proc), 0);
        bus.io_done = 1;
        bus.io_done_proc = 2;
        step();
        check("wake_next", int'(bus.next_proc), 2);
        check("wake_cause", int'(bus.switch_cause), 1);

        do_reset();
        start_run(1);
        ack();
        instrs(16);
        check("solo_no_req", int'(bus.switch_req), 0);
        check("solo_reload", int'(bus.quantum_left), 16);
        bus.proc_end = 1;
        step();
        check("solo_done", int'(bus.all_done), 1);
        check("solo_cur", int'(bus.cur_proc), 0);

        do_reset();
        start_run(2);
        ack();
        bus.proc_end = 1;
        bus.io_req = 1;
        step();
        check("both_cause", int'(bus.switch_cause), 2);
        ack();
        bus.proc_end = 1;
        step();
        check("both_finished", int'(bus.all_done), 1);

        do_reset();
        start_run(3);
        ack();
        instrs(16);
        #2;
        reset = 0;
        #1;
        check("async_req", int'(bus.switch_req), 0);
        check("async_cur", int'(bus.cur_proc), 0);
        check("async_base", int'(bus.next_pc_base), 0);

        for (int r = 0; r < 20; r++) begin
            do_reset();
            start_run(int'($urandom_range(15)));
            for (int c = 0; c < 300; c++) begin
                bus.start = ($urandom_range(99) < 3);
                bus.proc_count = 4'($urandom_range(15));
                bus.instr_valid = ($urandom_range(99) < 70);
                bus.io_req = ($urandom_range(99) < 5);
                bus.proc_end = ($urandom_range(99) < 3);
                bus.io_done = ($urandom_range(99) < 20);
                bus.io_done_proc = 4'($urandom_range(15));
                bus.switch_ack = ($urandom_range(99) < 50);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
